// File: rtl/i2s_pkg.sv
// Shared I2S constants for the receive and transmit controllers.
package i2s_pkg;

    localparam logic WS_LEFT       = 1'b0;
    localparam logic WS_RIGHT      = 1'b1;
    localparam int   I2S_DATA_BITS = 32;
    localparam int   I2S_SYNC_MIN  = 2;

    // Clamp a requested synchroniser depth to the safe minimum.
    function automatic int sync_depth(input int req);
        return (req < I2S_SYNC_MIN) ? I2S_SYNC_MIN : req;
    endfunction

endpackage

// File: rtl/i2s_sync_edge.sv
// One-bit multi-stage synchroniser with an optional rising-edge pulse output.
module i2s_sync_edge #(
    parameter int STAGES  = 2,
    parameter bit EDGE_EN = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic [STAGES-1:0] sync_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) sync_reg[0] <= 1'b0;
                    else          sync_reg[0] <= d;
                end
            end else begin : g_chain
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) sync_reg[gi] <= 1'b0;
                    else          sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign q = sync_reg[STAGES-1];

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) prev_reg <= 1'b0;
                else          prev_reg <= q;
            end
            // Combinational so the pulse lines up with the synced WS/SD bits.
            assign rise = q & ~prev_reg;
        end else begin : g_no_edge
            assign rise = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/i2s_rx_slave.sv
// Slave-mode I2S receiver: oversamples SCK/WS/SD, deserialises MSB-first words
// and presents left/right pairs as stereo frames on a valid/ready interface.
module i2s_rx_slave
    import i2s_pkg::*;
#(
    parameter int DATA_BITS   = I2S_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i2s_sck,
    input  logic                 i2s_ws,
    input  logic                 i2s_sd,
    output logic [DATA_BITS-1:0] left_data,
    output logic [DATA_BITS-1:0] right_data,
    output logic                 frame_valid,
    input  logic                 frame_ready,
    output logic                 locked,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    localparam int STAGES = sync_depth(SYNC_STAGES);
    localparam int CNT_W  = $clog2(DATA_BITS + 1);

    logic sck_s, sck_rise, ws_s, ws_rise, sd_s, sd_rise;
    logic unused_sync;

    i2s_sync_edge #(.STAGES(STAGES), .EDGE_EN(1'b1)) u_sync_sck (
        .clk(clk), .reset_n(reset_n), .d(i2s_sck), .q(sck_s), .rise(sck_rise)
    );
    i2s_sync_edge #(.STAGES(STAGES), .EDGE_EN(1'b0)) u_sync_ws (
        .clk(clk), .reset_n(reset_n), .d(i2s_ws), .q(ws_s), .rise(ws_rise)
    );
    i2s_sync_edge #(.STAGES(STAGES), .EDGE_EN(1'b0)) u_sync_sd (
        .clk(clk), .reset_n(reset_n), .d(i2s_sd), .q(sd_s), .rise(sd_rise)
    );

    assign unused_sync = &{1'b0, sck_s, ws_rise, sd_rise};

    logic                 ws_d_reg, ws_dd_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 word_ok_reg;
    logic                 locked_reg;
    logic                 have_left_reg;
    logic [DATA_BITS-1:0] left_hold_reg, right_hold_reg;
    logic                 frame_done_reg;
    logic [DATA_BITS-1:0] left_data_reg, right_data_reg;
    logic                 frame_valid_reg;
    logic                 overrun_reg;

    logic                 word_start;
    logic [DATA_BITS-1:0] bit_mask;
    logic [DATA_BITS-1:0] msb_one;

    // WS is one bit ahead of SD, so a change between the last two sampled WS
    // values marks the MSB of the new word.
    assign word_start = sck_rise && (ws_d_reg != ws_dd_reg);
    assign msb_one    = {1'b1, {(DATA_BITS-1){1'b0}}};
    assign bit_mask   = msb_one >> cnt_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ws_d_reg       <= 1'b0;
            ws_dd_reg      <= 1'b0;
            shift_reg      <= '0;
            cnt_reg        <= '0;
            word_ok_reg    <= 1'b0;
            locked_reg     <= 1'b0;
            have_left_reg  <= 1'b0;
            left_hold_reg  <= '0;
            right_hold_reg <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (sck_rise) begin
                ws_dd_reg <= ws_d_reg;
                ws_d_reg  <= ws_s;
                if (word_start) begin
                    locked_reg  <= 1'b1;
                    word_ok_reg <= 1'b1;
                    shift_reg   <= {sd_s, {(DATA_BITS-1){1'b0}}};
                    cnt_reg     <= CNT_W'(1);
                    // The word ending here only counts if it began after lock.
                    if (word_ok_reg) begin
                        if (ws_dd_reg == WS_LEFT) begin
                            left_hold_reg <= shift_reg;
                            have_left_reg <= 1'b1;
                        end else if (have_left_reg) begin
                            right_hold_reg <= shift_reg;
                            have_left_reg  <= 1'b0;
                            frame_done_reg <= 1'b1;
                        end
                    end
                end else if (cnt_reg < CNT_W'(DATA_BITS)) begin
                    if (sd_s) shift_reg <= shift_reg | bit_mask;
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            left_data_reg   <= '0;
            right_data_reg  <= '0;
            frame_valid_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            if (frame_done_reg) begin
                if (!frame_valid_reg || frame_ready) begin
                    left_data_reg   <= left_hold_reg;
                    right_data_reg  <= right_hold_reg;
                    frame_valid_reg <= 1'b1;
                end
            end else if (frame_valid_reg && frame_ready) begin
                frame_valid_reg <= 1'b0;
            end
            // A dropped frame wins over a same-cycle clear.
            if (frame_done_reg && frame_valid_reg && !frame_ready)
                overrun_reg <= 1'b1;
            else if (overrun_clr)
                overrun_reg <= 1'b0;
        end
    end

    assign left_data   = left_data_reg;
    assign right_data  = right_data_reg;
    assign frame_valid = frame_valid_reg;
    assign locked      = locked_reg;
    assign overrun     = overrun_reg;

endmodule
